// File: rtl/flash_sample_reader.sv
// rtl/flash_sample_reader.sv - fetches one 32-bit flash word per address and plays its two 8-bit samples
module flash_sample_reader #(
  parameter int ADDR_W  = 23,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              addr_valid,
  output logic              addr_ready,
  input  logic              direction,
  input  logic              sample_tick,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_address,
  input  logic              flash_waitrequest,
  input  logic [31:0]       flash_readdata,
  input  logic              flash_readdatavalid,
  output logic [7:0]        sample_out,
  output logic              sample_valid,
  output logic              word_done,
  output logic              timeout_err,
  output logic [15:0]       underrun_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    PLAY_FIRST,
    PLAY_SECOND
  } state_t;

  // Last counter value before the abort; the abort fires on the TIMEOUT-th wait cycle
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic        dir_q;
  logic [31:0] data_q;
  logic [7:0]  tmo_cnt;
  logic        fetching;

  // The generator may present a new address only while idle
  assign addr_ready = (state == IDLE);
  assign fetching   = (state == IDLE) || (state == REQ) || (state == WAIT_DATA);

  // Fetch/playback sequencer with registered Avalon and sample outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      dir_q         <= 1'b0;
      data_q        <= 32'd0;
      tmo_cnt       <= 8'd0;
      flash_read    <= 1'b0;
      flash_address <= '0;
      sample_out    <= 8'd0;
      sample_valid  <= 1'b0;
      word_done     <= 1'b0;
      timeout_err   <= 1'b0;
      underrun_cnt  <= 16'd0;
    end else begin
      sample_valid <= 1'b0;
      word_done    <= 1'b0;

      // A tick that arrives before data is ready is lost, so it is only counted
      if (sample_tick && fetching && (underrun_cnt != 16'hFFFF)) begin
        underrun_cnt <= underrun_cnt + 16'd1;
      end

      case (state)
        IDLE: begin
          if (addr_valid) begin
            flash_address <= addr_in;
            dir_q         <= direction;
            timeout_err   <= 1'b0;
            flash_read    <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          if (!flash_waitrequest) begin
            flash_read <= 1'b0;
            tmo_cnt    <= 8'd0;
            state      <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (flash_readdatavalid) begin
            data_q <= flash_readdata;
            state  <= PLAY_FIRST;
          end else if (tmo_cnt == TMO_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        PLAY_FIRST: begin
          if (sample_tick) begin
            sample_out   <= dir_q ? data_q[31:24] : data_q[15:8];
            sample_valid <= 1'b1;
            state        <= PLAY_SECOND;
          end
        end
        PLAY_SECOND: begin
          if (sample_tick) begin
            sample_out   <= dir_q ? data_q[15:8] : data_q[31:24];
            sample_valid <= 1'b1;
            word_done    <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_sample_reader.sv
// tb/tb_flash_sample_reader.sv - randomized self-checking bench for flash_sample_reader
module tb_flash_sample_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [22:0] addr_in = '0;
  logic        addr_valid = 1'b0;
  logic        addr_ready;
  logic        direction = 1'b0;
  logic        sample_tick = 1'b0;
  logic        flash_read;
  logic [22:0] flash_address;
  logic        flash_waitrequest = 1'b1;
  logic [31:0] flash_readdata = '0;
  logic        flash_readdatavalid = 1'b0;
  logic [7:0]  sample_out;
  logic        sample_valid;
  logic        word_done;
  logic        timeout_err;
  logic [15:0] underrun_cnt;

  int tests_run = 0;
  int failed = 0;
  int model_underrun = 0;
  logic [7:0] prev_sample = 8'd0;
  int acc_cnt = 0;

  flash_sample_reader #(.ADDR_W(23), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .addr_in(addr_in), .addr_valid(addr_valid),
    .addr_ready(addr_ready), .direction(direction), .sample_tick(sample_tick),
    .flash_read(flash_read), .flash_address(flash_address),
    .flash_waitrequest(flash_waitrequest), .flash_readdata(flash_readdata),
    .flash_readdatavalid(flash_readdatavalid), .sample_out(sample_out),
    .sample_valid(sample_valid), .word_done(word_done),
    .timeout_err(timeout_err), .underrun_cnt(underrun_cnt)
  );

  always #10 clk = ~clk;

  always @(posedge clk) if (rst_n && addr_ready && addr_valid) acc_cnt++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One complete word: accept, Avalon fetch with w waitrequest cycles and l latency cycles, play two samples.
  // nt ticks are dropped in during the fetch and must show up as underruns.
  task automatic do_word(input logic [22:0] a, input logic d, input logic [31:0] data,
                         input int w, input int l, input int nt, input bit hold);
    logic [7:0] e1, e2;
    int k;
    bit bad;
    e1 = d ? data[31:24] : data[15:8];
    e2 = d ? data[15:8]  : data[31:24];
    addr_in = a; direction = d; addr_valid = 1'b1;
    tests_run++;
    if (addr_ready !== 1'b1) begin failed++; $display("FAIL accept_ready: got %b expected 1", addr_ready); end
    step;
    if (!hold) addr_valid = 1'b0;
    direction = ~d;
    addr_in = 23'($urandom);
    tests_run++;
    if (flash_read !== 1'b1 || flash_address !== a) begin
      failed++; $display("FAIL req_start: read=%b addr=%h expected read=1 addr=%h", flash_read, flash_address, a);
    end
    k = 0; bad = 0;
    for (int i = 0; i <= w; i++) begin
      flash_waitrequest = (i < w);
      sample_tick = (k % 2 == 0) && (k / 2 < nt);
      if (sample_tick) model_underrun++;
      if (flash_read !== 1'b1 || flash_address !== a || addr_ready !== 1'b0) bad = 1;
      step; sample_tick = 1'b0; k++;
    end
    flash_waitrequest = 1'b1;
    tests_run++;
    if (bad || flash_read !== 1'b0) begin
      failed++; $display("FAIL req_phase: stable=%b read_after_accept=%b expected stable and read=0", !bad, flash_read);
    end
    for (int i = 0; i < l; i++) begin
      flash_readdata = $urandom;
      sample_tick = (k % 2 == 0) && (k / 2 < nt);
      if (sample_tick) model_underrun++;
      step; sample_tick = 1'b0; k++;
    end
    flash_readdatavalid = 1'b1; flash_readdata = data;
    step;
    flash_readdatavalid = 1'b0; flash_readdata = $urandom;
    tests_run++;
    if (sample_valid !== 1'b0 || sample_out !== prev_sample || underrun_cnt !== 16'(model_underrun)) begin
      failed++; $display("FAIL fetch_hold: valid=%b out=%h under=%0d expected valid=0 out=%h under=%0d",
                         sample_valid, sample_out, underrun_cnt, prev_sample, model_underrun);
    end
    repeat ($urandom_range(0, 3)) step;
    sample_tick = 1'b1; step; sample_tick = 1'b0;
    tests_run++;
    if (sample_valid !== 1'b1 || sample_out !== e1 || word_done !== 1'b0) begin
      failed++; $display("FAIL first_sample: valid=%b out=%h done=%b expected 1 %h 0", sample_valid, sample_out, word_done, e1);
    end
    prev_sample = e1;
    repeat ($urandom_range(0, 3)) begin
      step;
      tests_run++;
      if (sample_valid !== 1'b0 || flash_read !== 1'b0 || addr_ready !== 1'b0) begin
        failed++; $display("FAIL play_gap: valid=%b read=%b ready=%b expected 0 0 0", sample_valid, flash_read, addr_ready);
      end
    end
    sample_tick = 1'b1; step; sample_tick = 1'b0;
    tests_run++;
    if (sample_valid !== 1'b1 || sample_out !== e2 || word_done !== 1'b1) begin
      failed++; $display("FAIL second_sample: valid=%b out=%h done=%b expected 1 %h 1", sample_valid, sample_out, word_done, e2);
    end
    prev_sample = e2;
    tests_run++;
    if (addr_ready !== 1'b1 || underrun_cnt !== 16'(model_underrun)) begin
      failed++; $display("FAIL word_end: ready=%b under=%0d expected 1 %0d", addr_ready, underrun_cnt, model_underrun);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    tests_run++;
    if (addr_ready !== 1'b1 || flash_read !== 1'b0 || sample_out !== 8'd0 || sample_valid !== 1'b0 ||
        word_done !== 1'b0 || timeout_err !== 1'b0 || underrun_cnt !== 16'd0 || flash_address !== 23'd0) begin
      failed++; $display("FAIL reset_state: ready=%b read=%b out=%h under=%0d err=%b expected 1 0 00 0 0",
                         addr_ready, flash_read, sample_out, underrun_cnt, timeout_err);
    end
    step; step;
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_directed;
    do_word(23'h000010, 1'b0, 32'hA1B2C3D4, 3, 2, 0, 1'b0);
    do_word(23'h000010, 1'b1, 32'hA1B2C3D4, 3, 2, 0, 1'b0);
  endtask

  task automatic test_underrun;
    do_word(23'h000123, 1'b0, 32'h5566_7788, 5, 6, 4, 1'b0);
  endtask

  task automatic test_timeout;
    bit bad;
    addr_in = 23'h0000AA; direction = 1'b0; addr_valid = 1'b1;
    flash_waitrequest = 1'b0;
    step;
    addr_valid = 1'b0;
    step;
    flash_waitrequest = 1'b1;
    bad = 0;
    for (int i = 0; i < 254; i++) begin
      step;
      if (timeout_err !== 1'b0 || addr_ready !== 1'b0) bad = 1;
    end
    tests_run++;
    if (bad) begin failed++; $display("FAIL timeout_early: aborted before 255 wait cycles, expected still waiting"); end
    step;
    tests_run++;
    if (timeout_err !== 1'b1 || addr_ready !== 1'b1 || sample_valid !== 1'b0 || word_done !== 1'b0) begin
      failed++; $display("FAIL timeout_fire: err=%b ready=%b expected 1 1", timeout_err, addr_ready);
    end
    flash_readdatavalid = 1'b1; flash_readdata = 32'hDEADBEEF;
    step;
    flash_readdatavalid = 1'b0;
    step;
    tests_run++;
    if (sample_valid !== 1'b0 || addr_ready !== 1'b1 || timeout_err !== 1'b1) begin
      failed++; $display("FAIL stale_data: valid=%b ready=%b err=%b expected 0 1 1", sample_valid, addr_ready, timeout_err);
    end
    addr_in = 23'h0000AB; addr_valid = 1'b1;
    step;
    addr_valid = 1'b0;
    tests_run++;
    if (timeout_err !== 1'b0 || flash_read !== 1'b1) begin
      failed++; $display("FAIL timeout_clear: err=%b read=%b expected 0 1", timeout_err, flash_read);
    end
    flash_waitrequest = 1'b0; step; flash_waitrequest = 1'b1;
    flash_readdatavalid = 1'b1; flash_readdata = 32'h0102_0304; step; flash_readdatavalid = 1'b0;
    sample_tick = 1'b1; step; step; sample_tick = 1'b0;
    prev_sample = 8'h01;
    tests_run++;
    if (sample_out !== 8'h01 || word_done !== 1'b1) begin
      failed++; $display("FAIL recover_word: out=%h done=%b expected 01 1", sample_out, word_done);
    end
  endtask

  task automatic test_reset_mid_read;
    bit bad;
    addr_in = 23'h000777; addr_valid = 1'b1; flash_waitrequest = 1'b1;
    step;
    addr_valid = 1'b0;
    step;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (flash_read !== 1'b0 || addr_ready !== 1'b1 || underrun_cnt !== 16'd0 || sample_out !== 8'd0) begin
      failed++; $display("FAIL async_reset: read=%b ready=%b under=%0d expected 0 1 0", flash_read, addr_ready, underrun_cnt);
    end
    step;
    rst_n = 1'b1;
    model_underrun = 0; prev_sample = 8'd0;
    step;
    flash_readdatavalid = 1'b1; flash_readdata = 32'hCAFEF00D;
    step;
    flash_readdatavalid = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      sample_tick = (i % 2 == 0);
      if (sample_tick) model_underrun++;
      step;
      sample_tick = 1'b0;
      if (sample_valid !== 1'b0 || flash_read !== 1'b0) bad = 1;
    end
    step;
    tests_run++;
    if (bad || sample_out !== 8'd0 || addr_ready !== 1'b1 || underrun_cnt !== 16'(model_underrun)) begin
      failed++; $display("FAIL ignore_late_data: spurious=%b out=%h ready=%b under=%0d expected 0 00 1 %0d",
                         bad, sample_out, addr_ready, underrun_cnt, model_underrun);
    end
  endtask

  task automatic test_random;
    int w, l;
    for (int n = 0; n < 8; n++) begin
      w = $urandom_range(0, 4);
      l = $urandom_range(0, 8);
      do_word(23'($urandom), 1'($urandom), $urandom, w, l, $urandom_range(0, (w + 1 + l) / 2), 1'b0);
    end
  endtask

  task automatic test_back_to_back;
    int start;
    logic [22:0] a;
    start = acc_cnt;
    a = 23'h001000;
    for (int n = 0; n < 4; n++) begin
      do_word(a, 1'($urandom), $urandom, $urandom_range(0, 2), $urandom_range(0, 3), 0, 1'b1);
      a = a + 23'd1;
    end
    addr_valid = 1'b0;
    tests_run++;
    if (acc_cnt - start !== 4) begin
      failed++; $display("FAIL b2b_accepts: got %0d expected 4", acc_cnt - start);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_underrun;
    test_timeout;
    test_reset_mid_read;
    test_random;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
